// File: rtl/glip_loopback_endpoint.sv
// Logic-side GLIP FIFO endpoint: buffered loopback, counter generator and counter checker
// for backend bring-up. All outputs are derived from registered state only.
module glip_loopback_endpoint #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic             clk_logic,
   input  logic             rst,
   input  logic             logic_rst,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] fifo_in_data,
   input  logic             fifo_in_valid,
   output logic             fifo_in_ready,
   output logic [WIDTH-1:0] fifo_out_data,
   output logic             fifo_out_valid,
   input  logic             fifo_out_ready,
   output logic [31:0]      rx_count,
   output logic [15:0]      err_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

   typedef enum logic [1:0] {
      MODE_LOOP = 2'd0,
      MODE_GEN  = 2'd1,
      MODE_CHK  = 2'd2,
      MODE_IDLE = 2'd3
   } mode_e;

   mode_e            mode_q, mode_d;
   logic             block_q, block_d;
   logic [LW-1:0]    level_q, level_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] gen_q, gen_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic [31:0]      rx_count_q, rx_count_d;
   logic [15:0]      err_count_q, err_count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             mem_we;

   logic reset_any;
   logic in_fire;
   logic out_fire;

   assign reset_any = rst | logic_rst;
   assign in_fire   = fifo_in_valid & fifo_in_ready;
   assign out_fire  = fifo_out_valid & fifo_out_ready;
   assign rx_count  = rx_count_q;
   assign err_count = err_count_q;

   // block_q covers the cycle after reset or a mode change: both handshakes held low.
   always_comb begin
      fifo_in_ready  = 1'b0;
      fifo_out_valid = 1'b0;
      fifo_out_data  = '0;
      if (!block_q) begin
         case (mode_q)
            MODE_LOOP: begin
               fifo_in_ready  = (level_q != FULL_LEVEL);
               fifo_out_valid = (level_q != '0);
               fifo_out_data  = mem_q[rd_ptr_q];
            end
            MODE_GEN: begin
               fifo_in_ready  = 1'b1;
               fifo_out_valid = 1'b1;
               fifo_out_data  = gen_q;
            end
            MODE_CHK: begin
               fifo_in_ready  = 1'b1;
            end
            MODE_IDLE: begin
               fifo_in_ready  = 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      mode_d      = mode_q;
      block_d     = block_q;
      level_d     = level_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      gen_d       = gen_q;
      exp_d       = exp_q;
      rx_count_d  = rx_count_q + 32'(in_fire);
      err_count_d = err_count_q;
      mem_we      = 1'b0;

      if (reset_any) begin
         mode_d      = mode_e'(mode);
         block_d     = 1'b1;
         level_d     = '0;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         gen_d       = '0;
         exp_d       = '0;
         rx_count_d  = '0;
         err_count_d = '0;
      end else if (mode != mode_q) begin
         mode_d   = mode_e'(mode);
         block_d  = 1'b1;
         level_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         gen_d    = '0;
         exp_d    = '0;
      end else begin
         block_d = 1'b0;
         case (mode_q)
            MODE_LOOP: begin
               // ready already excludes the full case, so a pop never frees room for a same-edge push
               if (in_fire) begin
                  mem_we   = 1'b1;
                  wr_ptr_d = wr_ptr_q + AW'(1);
               end
               if (out_fire) begin
                  rd_ptr_d = rd_ptr_q + AW'(1);
               end
               level_d = level_q + LW'(in_fire) - LW'(out_fire);
            end
            MODE_GEN: begin
               if (out_fire) begin
                  gen_d = gen_q + WIDTH'(1);
               end
            end
            MODE_CHK: begin
               if (in_fire) begin
                  if (fifo_in_data != exp_q) begin
                     if (err_count_q != 16'hFFFF) begin
                        err_count_d = err_count_q + 16'd1;
                     end
                  end
                  exp_d = fifo_in_data + WIDTH'(1);
               end
            end
            MODE_IDLE: begin
               block_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_logic) begin
      mode_q      <= mode_d;
      block_q     <= block_d;
      level_q     <= level_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      gen_q       <= gen_d;
      exp_q       <= exp_d;
      rx_count_q  <= rx_count_d;
      err_count_q <= err_count_d;
   end

   // Buffer storage needs no reset: level_q gates every read.
   always_ff @(posedge clk_logic) begin
      if (mem_we) begin
         mem_q[wr_ptr_q] <= fifo_in_data;
      end
   end

endmodule

// File: tb/tb_glip_loopback_endpoint.sv
// Self-checking bench for glip_loopback_endpoint: a 16-bit instance for loopback/checker/mode
// tests and a 4-bit instance for generator wrap-around.
module tb_glip_loopback_endpoint;

   logic        clk_logic = 1'b0;
   logic        rst = 1'b1;
   logic        logic_rst = 1'b0;

   logic [1:0]  mode = 2'd0;
   logic [15:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] rx_cnt;
   logic [15:0] err_cnt;

   logic [1:0]  mode4 = 2'd1;
   logic [3:0]  in_data4 = '0;
   logic        in_valid4 = 1'b0;
   logic        in_ready4;
   logic [3:0]  out_data4;
   logic        out_valid4;
   logic        out_ready4 = 1'b0;
   logic [31:0] rx_cnt4;
   logic [15:0] err_cnt4;

   int total = 0;
   int bad = 0;
   logic [15:0] exp_q[$];

   always #5 clk_logic = ~clk_logic;

   glip_loopback_endpoint #(.WIDTH(16), .DEPTH(8)) dut (
      .clk_logic(clk_logic), .rst(rst), .logic_rst(logic_rst), .mode(mode),
      .fifo_in_data(in_data), .fifo_in_valid(in_valid), .fifo_in_ready(in_ready),
      .fifo_out_data(out_data), .fifo_out_valid(out_valid), .fifo_out_ready(out_ready),
      .rx_count(rx_cnt), .err_count(err_cnt)
   );

   glip_loopback_endpoint #(.WIDTH(4), .DEPTH(8)) dut4 (
      .clk_logic(clk_logic), .rst(rst), .logic_rst(logic_rst), .mode(mode4),
      .fifo_in_data(in_data4), .fifo_in_valid(in_valid4), .fifo_in_ready(in_ready4),
      .fifo_out_data(out_data4), .fifo_out_valid(out_valid4), .fifo_out_ready(out_ready4),
      .rx_count(rx_cnt4), .err_count(err_cnt4)
   );

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(posedge clk_logic);
      @(negedge clk_logic);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b1;
      in_data = 16'h1234;
      out_ready = 1'b1;
      step();
      step();
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'h0) begin
         bad++;
         $display("FAIL reset_handshake: ready=%b valid=%b data=%h, required 0 0 0000", in_ready, out_valid, out_data);
      end
      total++;
      if (rx_cnt !== 32'd0 || err_cnt !== 16'd0) begin
         bad++;
         $display("FAIL reset_counters: rx=%0d err=%0d, required 0 0", rx_cnt, err_cnt);
      end
      total++;
      if (out_valid4 !== 1'b0 || in_ready4 !== 1'b0) begin
         bad++;
         $display("FAIL reset_gen_instance: valid=%b ready=%b, required 0 0", out_valid4, in_ready4);
      end
      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      step();
   endtask

   task automatic test_loopback_single();
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL single_empty: valid=%b, required 0", out_valid);
      end
      in_valid = 1'b1;
      in_data = 16'hA5A5;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL single_ready: ready=%b, required 1", in_ready);
      end
      step();
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_data !== 16'hA5A5 || rx_cnt !== 32'd1) begin
         bad++;
         $display("FAIL single_latency: valid=%b data=%h rx=%0d, required 1 a5a5 1", out_valid, out_data, rx_cnt);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL single_drain: valid=%b, required 0", out_valid);
      end
   endtask

   task automatic test_loopback_fill();
      int k;
      int popped;
      int cyc;
      logic [15:0] e;
      k = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 20; c++) begin
         in_valid = (k < 10);
         in_data = 16'(k);
         if (in_valid && in_ready) begin
            exp_q.push_back(16'(k));
            k++;
         end
         step();
      end
      total++;
      if (k !== 8 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'd0) begin
         bad++;
         $display("FAIL fill_backpressure: accepted=%0d ready=%b valid=%b data=%h, required 8 0 1 0000", k, in_ready, out_valid, out_data);
      end
      out_ready = 1'b1;
      popped = 0;
      cyc = 0;
      while (!(k == 10 && exp_q.size() == 0) && cyc < 60) begin
         in_valid = (k < 10);
         in_data = 16'(k);
         if (out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL fill_order: unexpected word %h, required none", out_data);
            end else begin
               e = exp_q.pop_front();
               if (out_data !== e) begin
                  bad++;
                  $display("FAIL fill_order: data=%h, required %h", out_data, e);
               end
            end
            popped++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(16'(k));
            k++;
         end
         step();
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      total++;
      if (popped !== 10 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL fill_drain: popped=%0d valid=%b, required 10 0", popped, out_valid);
      end
      exp_q.delete();
   endtask

   task automatic test_full_simul();
      int k;
      int cyc;
      logic [15:0] e;
      k = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 12; c++) begin
         in_valid = (k < 8);
         in_data = 16'h0100 + 16'(k);
         if (in_valid && in_ready) begin
            exp_q.push_back(in_data);
            k++;
         end
         step();
      end
      in_valid = 1'b1;
      in_data = 16'h0100 + 16'(k);
      out_ready = 1'b1;
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL full_state: ready=%b valid=%b, required 0 1", in_ready, out_valid);
      end
      // Only a pop happens on this edge.
      if (out_valid) begin
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hDEAD;
         total++;
         if (out_data !== e) begin
            bad++;
            $display("FAIL full_pop: data=%h, required %h", out_data, e);
         end
      end
      if (in_ready) begin
         exp_q.push_back(in_data);
         k++;
      end
      step();
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL full_ready_rise: ready=%b, required 1", in_ready);
      end
      for (int c = 0; c < 10; c++) begin
         in_data = 16'h0100 + 16'(k);
         total++;
         if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL steady_level7: ready=%b valid=%b, required 1 1", in_ready, out_valid);
         end
         if (out_valid) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hDEAD;
            total++;
            if (out_data !== e) begin
               bad++;
               $display("FAIL steady_order: data=%h, required %h", out_data, e);
            end
         end
         if (in_ready) begin
            exp_q.push_back(in_data);
            k++;
         end
         step();
      end
      in_valid = 1'b0;
      cyc = 0;
      while (out_valid && cyc < 20) begin
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hDEAD;
         total++;
         if (out_data !== e) begin
            bad++;
            $display("FAIL full_drain_order: data=%h, required %h", out_data, e);
         end
         step();
         cyc++;
      end
      out_ready = 1'b0;
      total++;
      if (exp_q.size() !== 0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL full_drain_count: left=%0d valid=%b, required 0 0", exp_q.size(), out_valid);
      end
      exp_q.delete();
   endtask

   task automatic test_generator_wrap();
      logic [3:0] gen_exp;
      int fires;
      gen_exp = 4'd0;
      fires = 0;
      for (int c = 0; c < 44; c++) begin
         out_ready4 = (c % 2 == 0);
         total++;
         if (out_valid4 !== 1'b1 || out_data4 !== gen_exp) begin
            bad++;
            $display("FAIL gen_value: cycle=%0d valid=%b data=%h, required 1 %h", c, out_valid4, out_data4, gen_exp);
         end
         if (out_ready4 && out_valid4) begin
            gen_exp = gen_exp + 4'd1;
            fires++;
         end
         step();
      end
      out_ready4 = 1'b0;
      total++;
      if (fires !== 22 || out_data4 !== 4'd6) begin
         bad++;
         $display("FAIL gen_wrap: fires=%0d data=%h, required 22 6", fires, out_data4);
      end
   endtask

   task automatic test_checker();
      logic [15:0] vals [6];
      logic [15:0] exp_val;
      logic [15:0] err_m;
      vals = '{16'd0, 16'd1, 16'd2, 16'd7, 16'd8, 16'd5};
      mode = 2'd2;
      apply_reset();
      exp_val = 16'd0;
      err_m = 16'd0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_data = vals[i];
         total++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL chk_handshake: ready=%b valid=%b, required 1 0", in_ready, out_valid);
         end
         if (vals[i] != exp_val) err_m = err_m + 16'd1;
         exp_val = vals[i] + 16'd1;
         step();
      end
      in_valid = 1'b0;
      total++;
      if (err_cnt !== err_m || rx_cnt !== 32'd6) begin
         bad++;
         $display("FAIL chk_errors: err=%0d rx=%0d, required %0d 6", err_cnt, rx_cnt, err_m);
      end
      in_valid = 1'b1;
      in_data = 16'd0;
      for (int i = 0; i < 70000; i++) begin
         if (exp_val != 16'd0 && err_m != 16'hFFFF) err_m = err_m + 16'd1;
         exp_val = 16'd1;
         step();
      end
      in_valid = 1'b0;
      total++;
      if (err_cnt !== err_m || err_cnt !== 16'hFFFF || rx_cnt !== 32'd70006) begin
         bad++;
         $display("FAIL chk_saturate: err=%h rx=%0d, required %h 70006", err_cnt, rx_cnt, err_m);
      end
   endtask

   task automatic test_mode_switch_reset();
      mode = 2'd0;
      step();
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || err_cnt !== 16'hFFFF || rx_cnt !== 32'd70006) begin
         bad++;
         $display("FAIL flush_keep: ready=%b valid=%b err=%h rx=%0d, required 0 0 ffff 70006", in_ready, out_valid, err_cnt, rx_cnt);
      end
      step();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data = 16'h0C00 + 16'(i);
         step();
      end
      in_valid = 1'b0;
      total++;
      if (rx_cnt !== 32'd70009 || out_valid !== 1'b1 || out_data !== 16'h0C00) begin
         bad++;
         $display("FAIL switch_buffered: rx=%0d valid=%b data=%h, required 70009 1 0c00", rx_cnt, out_valid, out_data);
      end
      mode = 2'd1;
      in_valid = 1'b1;
      in_data = 16'h0C03;
      step();
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || rx_cnt !== 32'd70010) begin
         bad++;
         $display("FAIL switch_flush: ready=%b valid=%b rx=%0d, required 0 0 70010", in_ready, out_valid, rx_cnt);
      end
      step();
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_data !== 16'h0000 || in_ready !== 1'b1 || rx_cnt !== 32'd70010) begin
         bad++;
         $display("FAIL switch_gen_start: valid=%b data=%h ready=%b rx=%0d, required 1 0000 1 70010", out_valid, out_data, in_ready, rx_cnt);
      end
      logic_rst = 1'b1;
      step();
      logic_rst = 1'b0;
      total++;
      if (rx_cnt !== 32'd0 || err_cnt !== 16'd0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
         bad++;
         $display("FAIL logic_rst: rx=%0d err=%0d valid=%b ready=%b, required 0 0 0 0", rx_cnt, err_cnt, out_valid, in_ready);
      end
      step();
      total++;
      if (out_valid !== 1'b1 || out_data !== 16'h0000) begin
         bad++;
         $display("FAIL logic_rst_resume: valid=%b data=%h, required 1 0000", out_valid, out_data);
      end
   endtask

   initial begin
      @(negedge clk_logic);
      test_reset();
      test_loopback_single();
      test_loopback_fill();
      test_full_simul();
      test_generator_wrap();
      test_checker();
      test_mode_switch_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
